// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_pkg
// Description : Shared types and elaboration-time helpers for the servo PWM
//               array: FSM state encoding, ceil-log2 and derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pwm_pkg;

    // Calculation engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SLEW = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input longint value);
        int     result;
        longint rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // PWM frame length in clk cycles
    function automatic int calc_period(input longint clk_hz, input longint pwm_hz);
        return int'(clk_hz / pwm_hz);
    endfunction

    // Duty recalculation interval in clk cycles
    function automatic int calc_tick_div(input longint clk_hz, input longint update_hz);
        return int'(clk_hz / update_hz);
    endfunction

    // Half of the deflection range
    function automatic int calc_half(input int min_dc, input int max_dc);
        return (max_dc - min_dc) >>> 1;
    endfunction

    // Neutral pulse width
    function automatic int calc_centre(input int min_dc, input int max_dc);
        return min_dc + calc_half(min_dc, max_dc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_duty_calc.sv
`default_nettype none
// ============================================================================
// Module      : servo_duty_calc
// Description : Combinational clamp/scale of one channel's tilt into a pulse
//               width target, and slew-limited step of the current duty
//               toward the registered target. Shared by all channels.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_duty_calc
    import servo_pwm_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int DC_W     = 20,
    parameter int FS_SHIFT = 8,
    parameter int HALF     = 25_000,
    parameter int CENTRE   = 75_000,
    parameter int MAX_STEP = 1_000
) (
    input  logic [IN_W-1:0] abs_val,
    input  logic            neg,
    input  logic            invert,
    input  logic [DC_W-1:0] target_q,
    input  logic [DC_W-1:0] cur_duty,
    output logic [DC_W-1:0] target,
    output logic [DC_W-1:0] next_duty
);

    localparam int                 c_prod_w = IN_W + DC_W;
    localparam logic [IN_W-1:0]    c_full   = IN_W'(2 ** FS_SHIFT);
    localparam logic [c_prod_w-1:0] c_half  = c_prod_w'(HALF);
    localparam logic [DC_W-1:0]    c_centre = DC_W'(CENTRE);
    localparam logic [DC_W-1:0]    c_step   = DC_W'(MAX_STEP);

    logic [IN_W-1:0]     w_mag;
    logic [c_prod_w-1:0] w_prod;
    logic [DC_W-1:0]     w_off;
    logic [DC_W-1:0]     w_diff;

    // Clamp to full scale, scale onto the half range, apply direction
    always_comb begin
        w_mag  = (abs_val > c_full) ? c_full : abs_val;
        w_prod = c_prod_w'(w_mag) * c_half;
        w_off  = DC_W'(w_prod >> FS_SHIFT);
        target = (neg ^ invert) ? (c_centre - w_off) : (c_centre + w_off);
    end

    // Move toward the registered target by at most one step
    always_comb begin
        if (target_q >= cur_duty) begin
            w_diff    = target_q - cur_duty;
            next_duty = (w_diff <= c_step) ? target_q : (cur_duty + c_step);
        end else begin
            w_diff    = cur_duty - target_q;
            next_duty = (w_diff <= c_step) ? target_q : (cur_duty - c_step);
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array
// Description : N-channel servo PWM generator with a shared frame counter,
//               time-multiplexed duty engine, slew limiting and duty shadow
//               registers that only update at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array
    import servo_pwm_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int CLK_HZ      = 50_000_000,
    parameter int PWM_HZ      = 50,
    parameter int UPDATE_FREQ = 60,
    parameter int MIN_DC      = 50_000,
    parameter int MAX_DC      = 100_000,
    parameter int IN_W        = 16,
    parameter int FS_SHIFT    = 8,
    parameter int MAX_STEP    = 1_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*IN_W-1:0] abs_in,
    input  logic [N_CH-1:0]      neg_in,
    input  logic [N_CH-1:0]      invert,
    input  logic [N_CH-1:0]      enable,
    output logic [N_CH-1:0]      pwm_out,
    output logic                 busy
);

    localparam int c_period   = calc_period(CLK_HZ, PWM_HZ);
    localparam int c_tick_div = calc_tick_div(CLK_HZ, UPDATE_FREQ);
    localparam int c_half     = calc_half(MIN_DC, MAX_DC);
    localparam int c_centre   = calc_centre(MIN_DC, MAX_DC);
    localparam int c_dc_w     = clog2(c_period);
    localparam int c_td_w     = clog2(c_tick_div);
    localparam int c_ch_w     = (N_CH > 1) ? clog2(N_CH) : 1;

    localparam logic [c_dc_w-1:0] c_centre_dc = c_dc_w'(c_centre);
    localparam logic [c_dc_w-1:0] c_cnt_last  = c_dc_w'(c_period - 1);
    localparam logic [c_td_w-1:0] c_tick_last = c_td_w'(c_tick_div - 1);
    localparam logic [c_ch_w-1:0] c_last_ch   = c_ch_w'(N_CH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_dc_w-1:0]    r_cnt;
    logic [c_td_w-1:0]    r_tick_cnt;
    logic                 w_tick;
    logic                 w_frame_end;
    logic [c_ch_w-1:0]    r_ch;
    logic [N_CH*IN_W-1:0] r_abs;
    logic [N_CH-1:0]      r_neg;
    logic [N_CH-1:0]      r_inv;
    logic [c_dc_w-1:0]    r_target;
    logic [c_dc_w-1:0]    r_duty_next   [N_CH];
    logic [c_dc_w-1:0]    r_duty_active [N_CH];
    logic [N_CH-1:0]      r_pwm;

    logic [IN_W-1:0]      w_abs;
    logic                 w_neg;
    logic                 w_inv;
    logic [c_dc_w-1:0]    w_cur_duty;
    logic [c_dc_w-1:0]    w_target;
    logic [c_dc_w-1:0]    w_next_duty;

    assign w_tick      = (r_tick_cnt == c_tick_last);
    assign w_frame_end = (r_cnt == c_cnt_last);
    assign pwm_out     = r_pwm;

    // Frame counter and update-tick divider
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_cnt      <= w_frame_end ? '0 : r_cnt + 1'b1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and busy; ticks arriving outside IDLE are dropped
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                busy        = 1'b1;
                w_state_nxt = ST_SLEW;
            end
            ST_SLEW: begin
                busy        = 1'b1;
                w_state_nxt = (r_ch == c_last_ch) ? ST_IDLE : ST_CALC;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Input snapshot, channel index and registered target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abs    <= '0;
            r_neg    <= '0;
            r_inv    <= '0;
            r_ch     <= '0;
            r_target <= c_centre_dc;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_abs <= abs_in;
                        r_neg <= neg_in;
                        r_inv <= invert;
                        r_ch  <= '0;
                    end
                end
                ST_CALC: begin
                    r_target <= w_target;
                end
                ST_SLEW: begin
                    if (r_ch != c_last_ch) begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: begin
                    r_ch <= '0;
                end
            endcase
        end
    end

    // Select the current channel's snapshot and tracked duty
    always_comb begin
        w_abs      = '0;
        w_neg      = 1'b0;
        w_inv      = 1'b0;
        w_cur_duty = c_centre_dc;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == c_ch_w'(i)) begin
                w_abs      = r_abs[i*IN_W +: IN_W];
                w_neg      = r_neg[i];
                w_inv      = r_inv[i];
                w_cur_duty = r_duty_next[i];
            end
        end
    end

    servo_duty_calc #(
        .IN_W     (IN_W),
        .DC_W     (c_dc_w),
        .FS_SHIFT (FS_SHIFT),
        .HALF     (c_half),
        .CENTRE   (c_centre),
        .MAX_STEP (MAX_STEP)
    ) u_duty_calc (
        .abs_val   (w_abs),
        .neg       (w_neg),
        .invert    (w_inv),
        .target_q  (r_target),
        .cur_duty  (w_cur_duty),
        .target    (w_target),
        .next_duty (w_next_duty)
    );

    // Tracked duty written in SLEW; active copy refreshed on the last cycle of
    // each frame so a same-cycle SLEW write lands one frame later
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                r_duty_next[i]   <= c_centre_dc;
                r_duty_active[i] <= c_centre_dc;
            end else begin
                if ((r_state == ST_SLEW) && (r_ch == c_ch_w'(i))) begin
                    r_duty_next[i] <= w_next_duty;
                end
                if (w_frame_end) begin
                    r_duty_active[i] <= r_duty_next[i];
                end
            end
        end
    end

    // Registered pulse outputs, gated by enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_pwm[i] <= enable[i] & (r_cnt < r_duty_active[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_array
// Description : Self-checking bench for servo_pwm_array at PERIOD=1000,
//               TICK_DIV=500, MIN_DC=400, MAX_DC=600, MAX_STEP=10.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_servo_pwm_array;

    localparam int N_CH   = 3;
    localparam int IN_W   = 16;
    localparam int PERIOD = 1000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH*IN_W-1:0] abs_in;
    logic [N_CH-1:0]      neg_in;
    logic [N_CH-1:0]      invert;
    logic [N_CH-1:0]      enable;
    logic [N_CH-1:0]      pwm_out;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int meas_w [N_CH];

    typedef struct {
        logic [N_CH*IN_W-1:0] abs_v;
        logic [N_CH-1:0]      neg_v;
        logic [N_CH-1:0]      inv_v;
        int                   frames;
        int                   exp0;
        int                   exp1;
        int                   exp2;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    servo_pwm_array #(
        .N_CH        (N_CH),
        .CLK_HZ      (50_000_000),
        .PWM_HZ      (50_000),
        .UPDATE_FREQ (100_000),
        .MIN_DC      (400),
        .MAX_DC      (600),
        .IN_W        (IN_W),
        .FS_SHIFT    (8),
        .MAX_STEP    (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .abs_in  (abs_in),
        .neg_in  (neg_in),
        .invert  (invert),
        .enable  (enable),
        .pwm_out (pwm_out),
        .busy    (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Wait for pwm_out[0] to rise, then count high cycles of every channel
    // over one frame. Returns on the frame's last cycle.
    task automatic measure_frame();
        logic prev;
        logic cur;
        logic found;
        int   guard;
        prev  = pwm_out[0];
        found = 1'b0;
        guard = 0;
        while (!found && guard < 3 * PERIOD) begin
            @(negedge clk);
            cur   = pwm_out[0];
            found = !prev && cur;
            prev  = cur;
            guard++;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_start actual=timeout required=rising edge");
            for (int k = 0; k < N_CH; k++) meas_w[k] = -1;
            return;
        end
        for (int k = 0; k < N_CH; k++) meas_w[k] = 0;
        for (int c = 0; c < PERIOD; c++) begin
            if (c > 0) @(negedge clk);
            for (int k = 0; k < N_CH; k++) begin
                if (pwm_out[k]) meas_w[k]++;
            end
        end
    endtask

    task automatic check_widths(input string name, input int e0, input int e1, input int e2);
        check({name, "_w0"}, meas_w[0], e0);
        check({name, "_w1"}, meas_w[1], e1);
        check({name, "_w2"}, meas_w[2], e2);
    endtask

    initial begin
        int n;
        int slew_exp [7];

        // abs packed {ch2, ch1, ch0}
        vecs[0] = '{{16'd128, 16'd128, 16'd256}, 3'b110, 3'b010, 5, 600, 550, 450};
        vecs[1] = '{{16'd0, 16'd64, 16'd5000}, 3'b100, 3'b010, 6, 600, 475, 500};
        vecs[2] = '{{16'd300, 16'd256, 16'd0}, 3'b011, 3'b100, 8, 500, 400, 400};
        vecs[3] = '{{16'd200, 16'd3, 16'd1}, 3'b000, 3'b000, 12, 500, 501, 578};
        vecs[4] = '{{16'd100, 16'd255, 16'd257}, 3'b101, 3'b110, 8, 400, 401, 539};
        slew_exp = '{500, 510, 530, 550, 570, 590, 600};

        rst    = 1'b1;
        abs_in = '0;
        neg_in = '0;
        invert = '0;
        enable = 3'b111;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_busy", int'(busy), 0);

        // First tick at divider count 499; busy appears on the 500th cycle
        rst = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 2000);
        check("busy_latency", n, 500);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_length", n, 6);

        // Idle inputs: every channel at centre
        measure_frame();
        check_widths("centre", 500, 500, 500);

        // Full positive on ch0: width climbs by the slew limit each frame
        measure_frame();
        abs_in[15:0] = 16'd256;
        for (int f = 0; f < 7; f++) begin
            measure_frame();
            check($sformatf("slew_f%0d", f), meas_w[0], slew_exp[f]);
        end
        check("slew_ch1_hold", meas_w[1], 500);

        // Table of settled targets
        for (int v = 0; v < 5; v++) begin
            abs_in = vecs[v].abs_v;
            neg_in = vecs[v].neg_v;
            invert = vecs[v].inv_v;
            repeat (vecs[v].frames) measure_frame();
            check_widths($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].exp2);
        end

        // Disable ch2 mid-frame, retarget it, re-enable at a frame boundary
        repeat (100) @(negedge clk);
        check("en_pre_high", int'(pwm_out[2]), 1);
        enable[2] = 1'b0;
        @(negedge clk);
        check("en_off_ch2", int'(pwm_out[2]), 0);
        check("en_off_ch0", int'(pwm_out[0]), 1);
        abs_in[47:32] = 16'd128;
        neg_in[2]     = 1'b0;
        invert[2]     = 1'b0;
        repeat (4) measure_frame();
        check("en_disabled_w2", meas_w[2], 0);
        enable[2] = 1'b1;
        measure_frame();
        check("en_resume_w2", meas_w[2], 550);
        check("en_resume_w0", meas_w[0], 400);

        // Reset during the second CALC discards everything
        n = 0;
        while (!busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        measure_frame();
        check_widths("post_rst", 500, 500, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
